// File: rtl/dashcam_csr_pkg.sv
`default_nettype none
// dashcam_csr_pkg: shared word offsets, response encoding and byte-lane mask helper
// for the dashcam CSR bank and its interrupt block.
package dashcam_csr_pkg;

  // Word offsets of the interrupt/commit words, relative to N_RW + N_RO
  localparam int IRQ_STATUS_OFS = 0;
  localparam int IRQ_ENABLE_OFS = 1;
  localparam int COMMIT_OFS     = 2;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_ACK  = 2'd1,
    RESP_ERR  = 2'd2
  } csr_resp_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dashcam_csr_irq.sv
`default_nettype none
// dashcam_csr_irq: rising-edge capture into W1C status, byte-masked enable register,
// and a registered combined interrupt output.
module dashcam_csr_irq #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_src_i,
  input  logic             st_wr_i,
  input  logic             en_wr_i,
  input  logic [N_IRQ-1:0] wdat_i,
  input  logic [N_IRQ-1:0] wmask_i,
  output logic [N_IRQ-1:0] status_o,
  output logic [N_IRQ-1:0] enable_o,
  output logic             irq_o
);

  logic [N_IRQ-1:0] src_q;
  logic [N_IRQ-1:0] status_q, status_d;
  logic [N_IRQ-1:0] enable_q, enable_d;
  logic             irq_q;

  always_comb begin
    status_d = status_q;
    enable_d = enable_q;
    if (st_wr_i) begin
      status_d = status_q & ~(wdat_i & wmask_i);
    end
    // New edges are OR-ed after the clear so a coincident set survives
    status_d = status_d | (irq_src_i & ~src_q);
    if (en_wr_i) begin
      enable_d = (enable_q & ~wmask_i) | (wdat_i & wmask_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      status_q <= '0;
      enable_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      src_q    <= irq_src_i;
      status_q <= status_d;
      enable_q <= enable_d;
      irq_q    <= |(status_q & enable_q);
    end
  end

  assign status_o = status_q;
  assign enable_o = enable_q;
  assign irq_o    = irq_q;

endmodule
`default_nettype wire

// File: rtl/dashcam_csr_bank.sv
`default_nettype none
// dashcam_csr_bank: Wishbone-classic CSR bank with RW control words, RO status and W1C irqs.
// Build macro DASHCAM_CSR_SHADOW_EN: RW writes are staged and applied on a frame commit.
module dashcam_csr_bank
  import dashcam_csr_pkg::*;
#(
  parameter int                 ADDR_W = 8,
  parameter int                 N_RW   = 4,
  parameter int                 N_RO   = 5,
  parameter int                 N_IRQ  = 8,
  parameter logic [32*N_RW-1:0] RW_RST = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [32*N_RW-1:0]  rw_q_o,
  output logic [N_RW-1:0]     rw_we_o,
  input  logic [32*N_RO-1:0]  ro_i,
  input  logic [N_IRQ-1:0]    irq_src_i,
  input  logic                commit_i,
  output logic                irq_o
);

  localparam int KW = ADDR_W - 2;
  localparam logic [KW-1:0] IDX_STATUS = KW'(N_RW + N_RO + IRQ_STATUS_OFS);
  localparam logic [KW-1:0] IDX_ENABLE = KW'(N_RW + N_RO + IRQ_ENABLE_OFS);
`ifdef DASHCAM_CSR_SHADOW_EN
  localparam logic [KW-1:0] IDX_COMMIT = KW'(N_RW + N_RO + COMMIT_OFS);
  localparam int            N_MAP      = N_RW + N_RO + 3;
`else
  localparam int            N_MAP      = N_RW + N_RO + 2;
`endif

  logic               ack_q, err_q;
  logic [31:0]        dat_q;
  logic               req, wr;
  logic [KW-1:0]      idx;
  logic [31:0]        mask, rdata;
  csr_resp_e          resp;
  logic [N_IRQ-1:0]   irq_status, irq_enable;

  logic [32*N_RW-1:0] rw_q, rw_d, base, upd;
  logic [N_RW-1:0]    rw_we_q, rw_we_d, wr_hit;

  assign req  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign idx  = wb_adr_i[ADDR_W-1:2];
  assign mask = byte_mask(wb_sel_i);
  assign wr   = (resp == RESP_ACK) & wb_we_i;

  always_comb begin
    resp = RESP_NONE;
    if (req) begin
      if ((wb_adr_i[1:0] != 2'b00) || (idx >= KW'(N_MAP))) resp = RESP_ERR;
      else                                                  resp = RESP_ACK;
    end
  end

  // Read mux; RW words read from base (staging copy when shadowing is built in)
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_RW; i++) begin
      if (idx == KW'(i)) rdata = base[32*i +: 32];
    end
    for (int j = 0; j < N_RO; j++) begin
      if (idx == KW'(N_RW + j)) rdata = ro_i[32*j +: 32];
    end
    if (idx == IDX_STATUS) rdata = 32'(irq_status);
    if (idx == IDX_ENABLE) rdata = 32'(irq_enable);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= (resp == RESP_ACK);
      err_q <= (resp == RESP_ERR);
      if (resp == RESP_ACK)      dat_q <= rdata;
      else if (resp == RESP_ERR) dat_q <= '0;
    end
  end

  always_comb begin
    upd    = base;
    wr_hit = '0;
    for (int i = 0; i < N_RW; i++) begin
      if (wr && (idx == KW'(i))) begin
        upd[32*i +: 32] = (base[32*i +: 32] & ~mask) | (wb_dat_i & mask);
        wr_hit[i]       = |wb_sel_i;
      end
    end
  end

`ifdef DASHCAM_CSR_SHADOW_EN
  logic [32*N_RW-1:0] stage_q;
  logic [N_RW-1:0]    dirty_q, dirty_d;
  logic               commit;

  assign base   = stage_q;
  assign commit = commit_i | (wr && (idx == IDX_COMMIT) && wb_sel_i[0] && wb_dat_i[0]);

  // Active takes the pre-write staging; a write landing with the commit stays pending
  always_comb begin
    rw_d    = commit ? stage_q : rw_q;
    rw_we_d = commit ? dirty_q : '0;
    dirty_d = commit ? wr_hit  : (dirty_q | wr_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= RW_RST;
      dirty_q <= '0;
    end else begin
      stage_q <= upd;
      dirty_q <= dirty_d;
    end
  end
`else
  logic unused_commit;
  assign unused_commit = commit_i;
  assign base          = rw_q;

  always_comb begin
    rw_d    = upd;
    rw_we_d = wr_hit;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= RW_RST;
      rw_we_q <= '0;
    end else begin
      rw_q    <= rw_d;
      rw_we_q <= rw_we_d;
    end
  end

  dashcam_csr_irq #(
    .N_IRQ (N_IRQ)
  ) u_irq (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src_i (irq_src_i),
    .st_wr_i   (wr && (idx == IDX_STATUS)),
    .en_wr_i   (wr && (idx == IDX_ENABLE)),
    .wdat_i    (wb_dat_i[N_IRQ-1:0]),
    .wmask_i   (mask[N_IRQ-1:0]),
    .status_o  (irq_status),
    .enable_o  (irq_enable),
    .irq_o     (irq_o)
  );

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign rw_q_o   = rw_q;
  assign rw_we_o  = rw_we_q;

endmodule
`default_nettype wire

// File: tb/tb_dashcam_csr_bank.sv
`default_nettype none
// tb_dashcam_csr_bank: directed self-checking bench for dashcam_csr_bank (default parameters).
module tb_dashcam_csr_bank;

  localparam logic [127:0] RST_VAL = {32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h1234_5678};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   adr = '0;
  logic [31:0]  dat = '0;
  logic [3:0]   sel = '0;
  logic         we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic [31:0]  dat_o;
  logic         ack_o, err_o, irq_o;
  logic [127:0] rw_q;
  logic [3:0]   rw_we;
  logic [159:0] ro;
  logic [7:0]   src = '0;
  logic         commit = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ro = {32'h1000_0004, 32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};

  dashcam_csr_bank #(
    .ADDR_W (8),
    .N_RW   (4),
    .N_RO   (5),
    .N_IRQ  (8),
    .RW_RST (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_stb_i  (stb),
    .wb_cyc_i  (cyc),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack_o),
    .wb_err_o  (err_o),
    .rw_q_o    (rw_q),
    .rw_we_o   (rw_we),
    .ro_i      (ro),
    .irq_src_i (src),
    .commit_i  (commit),
    .irq_o     (irq_o)
  );

  // One single-beat transfer; results sampled 1ns after the edge that issues the response
  task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic ack, output logic err, output logic [31:0] rd, output logic [3:0] wep);
    @(negedge clk);
    adr = a; we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    ack = ack_o; err = err_o; rd = dat_o; wep = rw_we;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset;
    logic a, e; logic [31:0] r; logic [3:0] p;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL reset_resp ack=%b err=%b want 0 0", ack_o, err_o); end
    total++; if (dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h want=0", dat_o); end
    total++; if (irq_o !== 1'b0 || rw_we !== 4'h0) begin bad++; $display("FAIL reset_irq_we irq=%b we=%b want 0 0000", irq_o, rw_we); end
    total++; if (rw_q !== RST_VAL) begin bad++; $display("FAIL reset_rw got=%h want=%h", rw_q, RST_VAL); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      xfer(8'(4*k), 1'b0, 32'h0, 4'hF, a, e, r, p);
      total++; if (a !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL rst_read_ack k=%0d ack=%b err=%b want 1 0", k, a, e); end
      total++; if (r !== RST_VAL[32*k +: 32]) begin bad++; $display("FAIL rst_read k=%0d got=%h want=%h", k, r, RST_VAL[32*k +: 32]); end
    end
  endtask

  task automatic test_byte_lanes;
    logic a, e; logic [31:0] r; logic [3:0] p;
    xfer(8'h04, 1'b1, 32'hA5A5_1234, 4'b0011, a, e, r, p);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL bl_ack got=%b want=1", a); end
`ifdef DASHCAM_CSR_SHADOW_EN
    total++; if (p !== 4'b0000) begin bad++; $display("FAIL bl_we got=%b want=0000", p); end
    total++; if (rw_q[63:32] !== 32'h0) begin bad++; $display("FAIL bl_active got=%h want=0", rw_q[63:32]); end
`else
    total++; if (p !== 4'b0010) begin bad++; $display("FAIL bl_we got=%b want=0010", p); end
    total++; if (rw_q[63:32] !== 32'h0000_1234) begin bad++; $display("FAIL bl_active got=%h want=00001234", rw_q[63:32]); end
`endif
    @(posedge clk); #1;
    total++; if (rw_we !== 4'b0000) begin bad++; $display("FAIL bl_we_single got=%b want=0000", rw_we); end
    xfer(8'h04, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'h0000_1234) begin bad++; $display("FAIL bl_read got=%h want=00001234", r); end
    xfer(8'h04, 1'b1, 32'hFFFF_FFFF, 4'b1000, a, e, r, p);
    total++; if (r !== 32'h0000_1234) begin bad++; $display("FAIL bl_prewrite got=%h want=00001234", r); end
    xfer(8'h04, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'hFF00_1234) begin bad++; $display("FAIL bl_lane3 got=%h want=ff001234", r); end
    xfer(8'h08, 1'b1, 32'h0, 4'b0000, a, e, r, p);
    total++; if (a !== 1'b1 || p !== 4'b0000) begin bad++; $display("FAIL bl_sel0 ack=%b we=%b want 1 0000", a, p); end
    xfer(8'h08, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bl_sel0_keep got=%h want=deadbeef", r); end
  endtask

  task automatic test_errors;
    logic a, e; logic [31:0] r; logic [3:0] p;
    xfer(8'h00, 1'b0, 32'h0, 4'hF, a, e, r, p);
    xfer(8'hFC, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (e !== 1'b1 || a !== 1'b0 || r !== 32'h0) begin bad++; $display("FAIL err_unmapped err=%b ack=%b dat=%h want 1 0 0", e, a, r); end
    xfer(8'h02, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (e !== 1'b1 || a !== 1'b0 || r !== 32'h0) begin bad++; $display("FAIL err_misalign err=%b ack=%b dat=%h want 1 0 0", e, a, r); end
    xfer(8'h06, 1'b1, 32'h0BAD_0BAD, 4'hF, a, e, r, p);
    total++; if (e !== 1'b1 || p !== 4'b0000) begin bad++; $display("FAIL err_write err=%b we=%b want 1 0000", e, p); end
    xfer(8'h04, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'hFF00_1234) begin bad++; $display("FAIL err_nochange got=%h want=ff001234", r); end
  endtask

  task automatic test_ro;
    logic a, e; logic [31:0] r; logic [3:0] p;
    xfer(8'h10, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'h1000_0000) begin bad++; $display("FAIL ro_first got=%h want=10000000", r); end
    xfer(8'h20, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'h1000_0004) begin bad++; $display("FAIL ro_last got=%h want=10000004", r); end
    xfer(8'h14, 1'b1, 32'hFFFF_FFFF, 4'hF, a, e, r, p);
    total++; if (a !== 1'b1 || p !== 4'b0000) begin bad++; $display("FAIL ro_write ack=%b we=%b want 1 0000", a, p); end
    xfer(8'h14, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'h1000_0001) begin bad++; $display("FAIL ro_keep got=%h want=10000001", r); end
  endtask

  task automatic test_irq;
    logic a, e; logic [31:0] r; logic [3:0] p;
    xfer(8'h28, 1'b1, 32'h0000_0005, 4'hF, a, e, r, p);
    @(negedge clk); src = 8'h01;
    @(negedge clk); src = 8'h04;
    repeat (2) @(negedge clk);
    xfer(8'h24, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'h0000_0005) begin bad++; $display("FAIL irq_status got=%h want=00000005", r); end
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_out got=%b want=1", irq_o); end
    xfer(8'h28, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'h0000_0005) begin bad++; $display("FAIL irq_enable got=%h want=00000005", r); end
    xfer(8'h24, 1'b1, 32'h0000_0001, 4'hF, a, e, r, p);
    xfer(8'h24, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'h0000_0004) begin bad++; $display("FAIL irq_w1c got=%h want=00000004", r); end
    @(negedge clk); src = 8'h00;
    @(negedge clk);
    src = 8'h04; adr = 8'h24; we = 1'b1; dat = 32'h4; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    total++; if (ack_o !== 1'b1) begin bad++; $display("FAIL irq_race_ack got=%b want=1", ack_o); end
    @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
    xfer(8'h24, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'h0000_0004) begin bad++; $display("FAIL irq_set_wins got=%h want=00000004", r); end
    xfer(8'h24, 1'b1, 32'h0000_0004, 4'hF, a, e, r, p);
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_lag got=%b want=1", irq_o); end
    @(posedge clk); #1;
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b want=0", irq_o); end
    src = 8'h00;
  endtask

  task automatic test_back_to_back;
    logic [4:0] acks;
    @(negedge clk);
    adr = 8'h00; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      acks[i] = ack_o;
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    total++; if (acks !== 5'b10101) begin bad++; $display("FAIL b2b_acks got=%b want=10101", acks); end
    @(posedge clk); #1;
    total++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL b2b_tail ack=%b err=%b want 0 0", ack_o, err_o); end
  endtask

  task automatic test_commit;
    logic a, e; logic [31:0] r; logic [3:0] p;
`ifdef DASHCAM_CSR_SHADOW_EN
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    xfer(8'h00, 1'b1, 32'h0000_0001, 4'hF, a, e, r, p);
    total++; if (rw_q[31:0] !== 32'h1234_5678 || p !== 4'b0000) begin bad++; $display("FAIL sh_stage act=%h we=%b want 12345678 0000", rw_q[31:0], p); end
    xfer(8'h00, 1'b0, 32'h0, 4'hF, a, e, r, p);
    total++; if (r !== 32'h0000_0001) begin bad++; $display("FAIL sh_read got=%h want=00000001", r); end
    @(negedge clk); commit = 1'b1;
    @(posedge clk); #1;
    total++; if (rw_q[31:0] !== 32'h0000_0001 || rw_we !== 4'b0001) begin bad++; $display("FAIL sh_commit act=%h we=%b want 00000001 0001", rw_q[31:0], rw_we); end
    @(negedge clk); commit = 1'b0;
    xfer(8'h0C, 1'b1, 32'h0000_00AB, 4'hF, a, e, r, p);
    xfer(8'h2C, 1'b1, 32'h0000_0001, 4'hF, a, e, r, p);
    total++; if (a !== 1'b1 || p !== 4'b1000 || rw_q[127:96] !== 32'hAB) begin bad++; $display("FAIL sh_regcommit ack=%b we=%b w3=%h want 1 1000 000000ab", a, p, rw_q[127:96]); end
`else
    xfer(8'h2C, 1'b1, 32'h0000_0001, 4'hF, a, e, r, p);
    total++; if (e !== 1'b1 || a !== 1'b0) begin bad++; $display("FAIL commit_unmapped err=%b ack=%b want 1 0", e, a); end
    @(negedge clk); commit = 1'b1;
    @(posedge clk); #1;
    total++; if (rw_we !== 4'b0000 || rw_q[63:32] !== 32'hFF00_1234) begin bad++; $display("FAIL commit_ignored we=%b w1=%h want 0000 ff001234", rw_we, rw_q[63:32]); end
    @(negedge clk); commit = 1'b0;
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    adr = 8'h00; we = 1'b1; dat = 32'hFFFF_FFFF; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL rstmid_resp ack=%b err=%b want 0 0", ack_o, err_o); end
    @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ack_o !== 1'b0 || rw_q !== RST_VAL) begin bad++; $display("FAIL rstmid_after ack=%b rw=%h want 0 %h", ack_o, rw_q, RST_VAL); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_byte_lanes;
    test_errors;
    test_ro;
    test_irq;
    test_back_to_back;
    test_commit;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
